// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past each winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == PtrW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single registered RF write port.
// Define RFARB_SCOREBOARD_EN to enable the pending-write (RAW hazard) scoreboard.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = rf_pkg::XLEN,
  parameter int unsigned ADDR_W  = rf_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_w,
  output logic [XLEN-1:0]           rf_data_in,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ready,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [ADDR_W-1:0]         rd2_addr,
  output logic                      rd1_busy,
  output logic                      rd2_busy
);

  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic               xfer;
  rf_wr_t             wr_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid),
    .gnt  (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are accepted but never reach the RF; index and data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
    end else begin
      wr_q.we <= xfer && (sel_addr != REG_ZERO);
      if (xfer && (sel_addr != REG_ZERO)) begin
        wr_q.addr <= sel_addr;
        wr_q.data <= sel_data;
      end
    end
  end

  assign rf_we      = wr_q.we;
  assign rf_w       = wr_q.addr;
  assign rf_data_in = wr_q.data;

`ifdef RFARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign rsv_ready = (rsv_addr == REG_ZERO) || !busy_q[rsv_addr];

  // Clear first so a same-edge reservation of the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q.we) begin
      busy_d[wr_q.addr] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rd1_busy = busy_q[rd1_addr];
  assign rd2_busy = busy_q[rd2_addr];
`else
  logic unused_sb;
  assign unused_sb = ^{rsv_valid, rsv_addr, rd1_addr, rd2_addr};
  assign rsv_ready = 1'b1;
  assign rd1_busy  = 1'b0;
  assign rd2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a per-cycle behavioural model check.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int XW = 32;
`ifdef RFARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*XW-1:0] req_data = '0;
  logic            rf_we;
  logic [AW-1:0]   rf_w;
  logic [XW-1:0]   rf_data_in;
  logic            rsv_valid = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic            rsv_ready;
  logic [AW-1:0]   rd1_addr = '0;
  logic [AW-1:0]   rd2_addr = '0;
  logic            rd1_busy;
  logic            rd2_busy;

  regfile_wb_arbiter #(
    .NUM_REQ(N),
    .XLEN   (XW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_w      (rf_w),
    .rf_data_in(rf_data_in),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .rd1_busy  (rd1_busy),
    .rd2_busy  (rd2_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: pointer, pending RF write and busy set, updated from the rules directly.
  int          m_ptr = 0;
  bit          m_we = 0;
  int          m_w = 0;
  logic [31:0] m_data = '0;
  bit          m_busy[32];

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit m_rsv_ready();
    if (!SB || rsv_addr == 0) return 1'b1;
    return !m_busy[rsv_addr];
  endfunction

  function automatic bit m_rd_busy(input int a);
    if (!SB || a == 0) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_w = 0; m_data = '0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      int w;
      int a;
      bit rr;
      w  = m_winner();
      rr = m_rsv_ready();
      if (m_we) m_busy[m_w] = 0;
      if (SB && rsv_valid && rr && rsv_addr != 0) m_busy[rsv_addr] = 1;
      if (w >= 0) begin
        a = int'(req_addr[w*AW +: AW]);
        m_ptr = (w + 1) % N;
        if (a != 0) begin
          m_we = 1; m_w = a; m_data = req_data[w*XW +: XW];
        end else begin
          m_we = 0;
        end
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rdy;
    w = m_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("cmp_req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("cmp_rf_we", 64'(rf_we), 64'(m_we));
    chk("cmp_rf_w", 64'(rf_w), 64'(m_w));
    chk("cmp_rf_data", 64'(rf_data_in), 64'(m_data));
    chk("cmp_rsv_ready", 64'(rsv_ready), 64'(m_rsv_ready()));
    chk("cmp_rd1_busy", 64'(rd1_busy), 64'(m_rd_busy(int'(rd1_addr))));
    chk("cmp_rd2_busy", 64'(rd2_busy), 64'(m_rd_busy(int'(rd2_addr))));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [XW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*XW +: XW] = d;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_w", 64'(rf_w), 64'd0);
    chk("rst_rf_data", 64'(rf_data_in), 64'd0);
    chk("rst_rd1_busy", 64'(rd1_busy), 64'd0);
    chk("rst_rd2_busy", 64'(rd2_busy), 64'd0);
    chk("rst_rsv_ready", 64'(rsv_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // All three valid for six cycles: strict 0,1,2 rotation, back-to-back writes
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), XW'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk("rr_rf_we", 64'(rf_we), 64'd1);
        chk("rr_rf_w", 64'(rf_w), 64'((k - 1) % 3 + 1));
      end
      tick();
    end
    req_valid = '0;
    chk("rr_last_w", 64'(rf_w), 64'd3);
    chk("rr_last_data", 64'(rf_data_in), 64'd2);
    tick();
    chk("rr_idle_we", 64'(rf_we), 64'd0);

    // Single req0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("s0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk("s0_rf_we", 64'(rf_we), 64'd1);
    chk("s0_rf_w", 64'(rf_w), 64'd5);
    chk("s0_rf_data", 64'(rf_data_in), 64'hDEADBEEF);
    tick();
    chk("s0_rf_we_off", 64'(rf_we), 64'd0);

    // x0 write from req1: accepted, no RF write, port holds
    set_req(1, 1'b1, 5'd0, 32'd7);
    #1;
    chk("x0_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    chk("x0_rf_we", 64'(rf_we), 64'd0);
    chk("x0_rf_w_hold", 64'(rf_w), 64'd5);
    chk("x0_rf_data_hold", 64'(rf_data_in), 64'hDEADBEEF);
    tick();

    // Scoreboard: reserve x7, hazard visible, double reservation refused
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1;
    chk("sb_rsv7_ready", 64'(rsv_ready), 64'd1);
    tick();
    rsv_valid = 1'b0; rd1_addr = 5'd7;
    #1;
    chk("sb_rd1_busy", 64'(rd1_busy), 64'(SB));
    rsv_valid = 1'b1;
    #1;
    chk("sb_rsv7_again", 64'(rsv_ready), 64'(!SB));
    rsv_valid = 1'b0;
    // Writeback to x7 via req2 (pointer is at 2)
    set_req(2, 1'b1, 5'd7, 32'h77);
    #1;
    chk("sb_wb_ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    chk("sb_wb_we", 64'(rf_we), 64'd1);
    chk("sb_busy_during_we", 64'(rd1_busy), 64'(SB));
    tick();
    chk("sb_busy_cleared", 64'(rd1_busy), 64'd0);
    // Unreserved write to x7, reserved again during its rf_we cycle: set wins
    set_req(0, 1'b1, 5'd7, 32'h78);
    tick();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1;
    chk("sb_same_edge_rdy", 64'(rsv_ready), 64'd1);
    tick();
    rsv_valid = 1'b0;
    chk("sb_set_wins", 64'(rd1_busy), 64'(SB));
    chk("sb_x0_never_busy", 64'(rd2_busy), 64'd0);

    // Mid-operation reset: x3 reserved and being written (pointer at 1)
    rsv_valid = 1'b1; rsv_addr = 5'd3; rd2_addr = 5'd3;
    tick();
    rsv_valid = 1'b0;
    set_req(1, 1'b1, 5'd3, 32'h33);
    tick();
    req_valid = '0;
    chk("mr_pre_we", 64'(rf_we), 64'd1);
    chk("mr_pre_busy", 64'(rd2_busy), 64'(SB));
    rst_n = 1'b0;
    #1;
    chk("mr_we_drop", 64'(rf_we), 64'd0);
    chk("mr_w_zero", 64'(rf_w), 64'd0);
    chk("mr_busy_clr", 64'(rd2_busy), 64'd0);
    chk("mr_busy7_clr", 64'(rd1_busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_pulse", 64'(rf_we), 64'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 10), XW'(i));
    #1;
    chk("mr_grant_req0", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk("mr_rf_w", 64'(rf_w), 64'd10);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
